reg_bus_target: RTL and testbench
=================================

# reg_bus_target

Per-component responder on the tile register bus: accepts the one-cycle write and read strobes issued by the tile's OCL command block and returns read data with a single-cycle valid pulse. Each instance holds control/scratch registers plus a bank of event counters with atomic snapshot. It sits inside any component that owns a `reg_bus` index (cores, coalescer, splitter, queues), and it is how host software configures and profiles that component.

## Interface
- `N_EVENTS`, 8: number of event inputs/counters, 1..24.
- `COMP_ID`, 0: component index on the reg bus, 0..255; returned by the ID register.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `reg_bus_wvalid`  in  1  this component's write strobe, one cycle per write.
- `reg_bus_waddr`  in  16  write byte address; only [7:0] decoded.
- `reg_bus_wdata`  in  32  write data.
- `reg_bus_arvalid`  in  1  read strobe, one cycle per read.
- `reg_bus_araddr`  in  16  read byte address; only [7:0] decoded.
- `reg_bus_rvalid`  out  1  read response pulse.
- `reg_bus_rdata`  out  32  read response data, valid with `reg_bus_rvalid`.
- `event_in`  in  N_EVENTS  per-cycle event pulses from the host component.
- `count_en`  out  1  CTRL[0], exported to the component.
- `alert`  out  1  sticky counter-overflow flag.

## Operation
- Register map (addr[7:0]):
  - 0x00 CTRL RW [1:0]: bit0 = count_en, bit1 = clear_on_snap.
  - 0x04 SNAP: write (any data) latches all live counters into shadows; read returns the 16-bit snapshot count, zero-extended.
  - 0x08 SCRATCH RW 32.
  - 0x0C EVENT_MASK RW [N_EVENTS-1:0]; reset value all ones.
  - 0x10/0x14 CYCLES_LSB/MSB RO: shadow of the 64-bit enabled-cycle counter.
  - 0x20+4*i CNT_i RO: shadow of 32-bit counter i.
  - 0x84 ALERT_CLR: write clears `alert`; read returns {31'b0, alert}.
  - 0xFC ID RO: {16'h5247, 8'h00, COMP_ID[7:0]}.
  - Any other read address returns 0. Writes to RO/unmapped addresses are ignored.
- Live counting: while count_en=1, the cycle counter increments every cycle, and counter i increments on each cycle with `event_in[i] & EVENT_MASK[i]`.
- SNAP write in cycle T: each shadow takes the live value as of the start of cycle T. The snapshot count increments and wraps at 16 bits. If clear_on_snap=1, each live counter loads the value of its own cycle-T increment (0 or 1), not 0, so no event is lost.
- Reset values: all registers 0 except EVENT_MASK; `reg_bus_rvalid`=0, `reg_bus_rdata`=0, `count_en`=0, `alert`=0.

## Timing
- Write: `reg_bus_wvalid` high in cycle T. Register updated at the T→T+1 edge and visible to reads decoded from T+1.
- Read pipeline, fixed 2-cycle latency:
  - Stage 1: `reg_bus_arvalid` in cycle T captures araddr.
  - Stage 2: in T+1, data is muxed from the current register values and registered.
  - `reg_bus_rvalid`=1 for exactly cycle T+2.
- Back-to-back strobes on consecutive cycles are fully pipelined and answered in order, one per cycle. There is no backpressure.
- Write and read to the same register in the same cycle T: the read returns the new value.
- `reg_bus_rdata` holds its last value when `reg_bus_rvalid`=0.
- `rst` asserted at any time clears everything immediately, including in-flight reads. No rvalid is produced for reads strobed before reset.
- A `event_in` pulse on a cycle with count_en=0 is not counted.

## Configuration
- `REG_TARGET_SAT_EN` defined: live counters saturate at 0xFFFFFFFF. The cycle counter saturates at 2^64-1. `alert` sets on the cycle any counter would exceed its maximum.
- Not defined: counters wrap to 0. `alert` sets on the cycle of the wrap.
- In both builds, `alert` stays 1 until an ALERT_CLR write or reset. If a clear and a new overflow happen in the same cycle, the overflow wins.

## Test plan
- Reset, then read 0x0C, 0xFC (COMP_ID=3), 0x50 → rvalid exactly 2 cycles after each arvalid; data 0x000000FF (N_EVENTS=8), 0x52470003, 0x00000000.
- Write SCRATCH=0xA5A5_1234, then read it in the next cycle → 0xA5A51234. Issue 3 reads on consecutive cycles → 3 consecutive rvalid pulses in order.
- CTRL=1, EVENT_MASK=0x05, drive `event_in`=0xFF for 10 cycles, CTRL=0, write SNAP → CNT_0=10, CNT_1=0, CNT_2=10, SNAP read=1.
- CTRL=3, event_in[0] held high, SNAP twice 20 cycles apart → second CNT_0 snapshot=20, with no lost or double-counted events.
- Preload by counting to 0xFFFFFFFF (forced), one more event → `REG_TARGET_SAT_EN` build: CNT_0=0xFFFFFFFF, alert=1; other build: CNT_0=0, alert=1. Write ALERT_CLR → alert=0.
- Assert `rst` one cycle after arvalid → no rvalid ever appears for that read, and all outputs read 0 immediately.

Source files
------------

// File: rtl/reg_bus_target_if.sv
// reg_bus_target_if: tile register bus bundle (write/read strobes and read response)
interface reg_bus_target_if;
    logic        reg_bus_wvalid;
    logic [15:0] reg_bus_waddr;
    logic [31:0] reg_bus_wdata;
    logic        reg_bus_arvalid;
    logic [15:0] reg_bus_araddr;
    logic        reg_bus_rvalid;
    logic [31:0] reg_bus_rdata;

    modport master (
        output reg_bus_wvalid, reg_bus_waddr, reg_bus_wdata, reg_bus_arvalid, reg_bus_araddr,
        input  reg_bus_rvalid, reg_bus_rdata
    );

    modport slave (
        input  reg_bus_wvalid, reg_bus_waddr, reg_bus_wdata, reg_bus_arvalid, reg_bus_araddr,
        output reg_bus_rvalid, reg_bus_rdata
    );
endinterface

// File: rtl/reg_bus_target.sv
// reg_bus_target: reg-bus responder with control/scratch registers and snapshotted event counters
// Build option REG_TARGET_SAT_EN: counters saturate instead of wrapping.
module reg_bus_target #(
    parameter int N_EVENTS = 8,
    parameter int COMP_ID  = 0
) (
    input  logic                clk,
    input  logic                rst,
    reg_bus_target_if.slave     bus,
    input  logic [N_EVENTS-1:0] event_in,
    output logic                count_en,
    output logic                alert
);
    logic [1:0]                ctrl_q, ctrl_d;
    logic [15:0]               snap_cnt_q, snap_cnt_d;
    logic [31:0]               scratch_q, scratch_d;
    logic [N_EVENTS-1:0]       mask_q, mask_d;
    logic [63:0]               cyc_q, cyc_d, cyc_shd_q, cyc_shd_d;
    logic [N_EVENTS-1:0][31:0] cnt_q, cnt_d, shd_q, shd_d;
    logic                      alert_q, alert_d;
    logic                      ar_q;
    logic [7:0]                ra_q;
    logic                      rvalid_q;
    logic [31:0]               rdata_q, rd_d;
    logic [7:0]                wa;
    logic                      wr, snap, restart, ovf;
    logic [N_EVENTS-1:0]       ev;
    logic                      unused_addr_hi;

    assign wa             = bus.reg_bus_waddr[7:0];
    assign wr             = bus.reg_bus_wvalid;
    assign snap           = wr && (wa == 8'h04);
    assign restart        = snap && ctrl_q[1];
    assign ev             = event_in & mask_q & {N_EVENTS{ctrl_q[0]}};
    assign unused_addr_hi = ^{bus.reg_bus_waddr[15:8], bus.reg_bus_araddr[15:8]};

    // Live counters keep this cycle's increment on a clearing snapshot so no event is dropped
    always_comb begin
        ovf = ctrl_q[0] && (cyc_q == '1) && !restart;
`ifdef REG_TARGET_SAT_EN
        cyc_d = restart ? 64'(ctrl_q[0]) : (ovf ? cyc_q : cyc_q + 64'(ctrl_q[0]));
`else
        cyc_d = restart ? 64'(ctrl_q[0]) : cyc_q + 64'(ctrl_q[0]);
`endif
        cyc_shd_d = snap ? cyc_q : cyc_shd_q;
        for (int i = 0; i < N_EVENTS; i++) begin
            shd_d[i] = snap ? cnt_q[i] : shd_q[i];
`ifdef REG_TARGET_SAT_EN
            cnt_d[i] = restart ? 32'(ev[i]) : ((ev[i] && cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + 32'(ev[i]));
`else
            cnt_d[i] = restart ? 32'(ev[i]) : cnt_q[i] + 32'(ev[i]);
`endif
            ovf = ovf | (ev[i] && (cnt_q[i] == '1) && !restart);
        end
    end

    // Host writes; a new overflow beats a simultaneous alert clear
    always_comb begin
        ctrl_d     = (wr && wa == 8'h00) ? bus.reg_bus_wdata[1:0] : ctrl_q;
        scratch_d  = (wr && wa == 8'h08) ? bus.reg_bus_wdata : scratch_q;
        mask_d     = (wr && wa == 8'h0C) ? bus.reg_bus_wdata[N_EVENTS-1:0] : mask_q;
        snap_cnt_d = snap_cnt_q + 16'(snap);
        alert_d    = ovf | (alert_q & !(wr && wa == 8'h84));
    end

    // Read data select from register state as it stands one cycle after the strobe
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < N_EVENTS; i++)
            if (ra_q == 8'(32 + 4 * i)) rd_d = shd_q[i];
        case (ra_q)
            8'h00:   rd_d = {30'b0, ctrl_q};
            8'h04:   rd_d = {16'b0, snap_cnt_q};
            8'h08:   rd_d = scratch_q;
            8'h0C:   rd_d = 32'(mask_q);
            8'h10:   rd_d = cyc_shd_q[31:0];
            8'h14:   rd_d = cyc_shd_q[63:32];
            8'h84:   rd_d = {31'b0, alert_q};
            8'hFC:   rd_d = {16'h5247, 8'h00, 8'(COMP_ID)};
            default: ;
        endcase
    end

    // State update; reset also discards any read still in the pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            snap_cnt_q <= '0;
            scratch_q  <= '0;
            mask_q     <= '1;
            cyc_q      <= '0;
            cyc_shd_q  <= '0;
            cnt_q      <= '0;
            shd_q      <= '0;
            alert_q    <= 1'b0;
            ar_q       <= 1'b0;
            ra_q       <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            snap_cnt_q <= snap_cnt_d;
            scratch_q  <= scratch_d;
            mask_q     <= mask_d;
            cyc_q      <= cyc_d;
            cyc_shd_q  <= cyc_shd_d;
            cnt_q      <= cnt_d;
            shd_q      <= shd_d;
            alert_q    <= alert_d;
            ar_q       <= bus.reg_bus_arvalid;
            ra_q       <= bus.reg_bus_arvalid ? bus.reg_bus_araddr[7:0] : ra_q;
            rvalid_q   <= ar_q;
            rdata_q    <= ar_q ? rd_d : rdata_q;
        end
    end

    assign bus.reg_bus_rvalid = rvalid_q;
    assign bus.reg_bus_rdata  = rdata_q;
    assign count_en           = ctrl_q[0];
    assign alert              = alert_q;
endmodule

// File: tb/tb_reg_bus_target.sv
// tb_reg_bus_target: vector table, directed corner sequences and random traffic against a reference model
module tb_reg_bus_target;
`ifdef REG_TARGET_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] event_in = '0;
    logic       count_en, alert;
    logic [7:0] ev_g = '0;
    int         n_cmp = 0;
    int         n_bad = 0;

    reg_bus_target_if bus();

    reg_bus_target #(.N_EVENTS(8), .COMP_ID(3)) dut (
        .clk(clk), .rst(rst), .bus(bus), .event_in(event_in), .count_en(count_en), .alert(alert)
    );

    always #5 clk = ~clk;

    // reference model state, in register-map terms
    logic [1:0]  m_ctrl;
    logic [31:0] m_scratch;
    logic [7:0]  m_mask;
    logic [15:0] m_snaps;
    logic [31:0] m_cnt [8];
    logic [31:0] m_shd [8];
    logic [63:0] m_cyc, m_cyc_shd;
    logic        m_alert;
    logic        p0v, p1v;
    logic [31:0] p0d, p1d, m_rdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ctrl = '0; m_scratch = '0; m_mask = 8'hFF; m_snaps = '0;
        m_cyc = '0; m_cyc_shd = '0; m_alert = 1'b0;
        for (int i = 0; i < 8; i++) begin m_cnt[i] = '0; m_shd[i] = '0; end
        p0v = 1'b0; p1v = 1'b0; p0d = '0; p1d = '0; m_rdata = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        if (a >= 8'h20 && a < 8'h40 && a[1:0] == 2'b00) return m_shd[(a - 8'h20) >> 2];
        case (a)
            8'h00: return {30'b0, m_ctrl};
            8'h04: return {16'b0, m_snaps};
            8'h08: return m_scratch;
            8'h0C: return {24'b0, m_mask};
            8'h10: return m_cyc_shd[31:0];
            8'h14: return m_cyc_shd[63:32];
            8'h84: return {31'b0, m_alert};
            8'hFC: return 32'h5247_0003;
            default: return 32'h0;
        endcase
    endfunction

    // one clock cycle of the specified behaviour
    task automatic m_step(input logic wv, input logic [7:0] wa, input logic [31:0] wd,
                          input logic rv, input logic [7:0] ra, input logic [7:0] e);
        logic en, clr, snap, ovf;
        longint nxt;
        en = m_ctrl[0]; clr = m_ctrl[1]; snap = wv && wa == 8'h04; ovf = 1'b0;
        if (snap) begin
            for (int i = 0; i < 8; i++) m_shd[i] = m_cnt[i];
            m_cyc_shd = m_cyc;
            m_snaps = m_snaps + 16'd1;
        end
        for (int i = 0; i < 8; i++) begin
            nxt = longint'(m_cnt[i]) + ((en && e[i] && m_mask[i]) ? 1 : 0);
            if (snap && clr) m_cnt[i] = (en && e[i] && m_mask[i]) ? 32'd1 : 32'd0;
            else if (nxt > 64'hFFFF_FFFF) begin ovf = 1'b1; m_cnt[i] = SAT ? 32'hFFFF_FFFF : 32'd0; end
            else m_cnt[i] = nxt[31:0];
        end
        if (snap && clr) m_cyc = en ? 64'd1 : 64'd0;
        else if (en && m_cyc == '1) begin ovf = 1'b1; m_cyc = SAT ? m_cyc : 64'd0; end
        else if (en) m_cyc = m_cyc + 64'd1;
        if (wv && wa == 8'h00) m_ctrl = wd[1:0];
        if (wv && wa == 8'h08) m_scratch = wd;
        if (wv && wa == 8'h0C) m_mask = wd[7:0];
        m_alert = ovf | (m_alert & !(wv && wa == 8'h84));
        p1v = p0v; p1d = p0d;
        p0v = rv; p0d = m_read(ra);
        if (p1v) m_rdata = p1d;
    endtask

    task automatic idle_inputs();
        bus.reg_bus_wvalid = 1'b0; bus.reg_bus_waddr = '0; bus.reg_bus_wdata = '0;
        bus.reg_bus_arvalid = 1'b0; bus.reg_bus_araddr = '0; event_in = '0;
    endtask

    task automatic cycle(input logic wv, input logic [15:0] wa, input logic [31:0] wd,
                         input logic rv, input logic [15:0] ra);
        @(negedge clk);
        bus.reg_bus_wvalid = wv; bus.reg_bus_waddr = wa; bus.reg_bus_wdata = wd;
        bus.reg_bus_arvalid = rv; bus.reg_bus_araddr = ra; event_in = ev_g;
        @(posedge clk);
        m_step(wv, wa[7:0], wd, rv, ra[7:0], ev_g);
        #1;
        chk("rvalid", 64'(bus.reg_bus_rvalid), 64'(p1v));
        chk("rdata", 64'(bus.reg_bus_rdata), 64'(m_rdata));
        chk("count_en", 64'(count_en), 64'(m_ctrl[0]));
        chk("alert", 64'(alert), 64'(m_alert));
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cycle(1'b1, {8'h0, a}, d, 1'b0, 16'h0);
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string nm);
        cycle(1'b0, 16'h0, 32'h0, 1'b1, {8'h0, a});
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 16'h0);
        chk({nm, " rvalid"}, 64'(bus.reg_bus_rvalid), 64'd1);
        chk(nm, 64'(bus.reg_bus_rdata), 64'(exp));
    endtask

    typedef struct {
        logic        do_wr;
        logic [7:0]  waddr;
        logic [31:0] wdata;
        logic [7:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];
    logic [7:0] raddrs [16];

    initial begin
        vecs[0] = '{1'b0, 8'h00, 32'h0,         8'h0C, 32'h0000_00FF};
        vecs[1] = '{1'b0, 8'h00, 32'h0,         8'hFC, 32'h5247_0003};
        vecs[2] = '{1'b0, 8'h00, 32'h0,         8'h50, 32'h0};
        vecs[3] = '{1'b0, 8'h00, 32'h0,         8'h00, 32'h0};
        vecs[4] = '{1'b1, 8'h08, 32'hA5A5_1234, 8'h08, 32'hA5A5_1234};
        vecs[5] = '{1'b1, 8'h0C, 32'h0000_01FF, 8'h0C, 32'h0000_00FF};
        vecs[6] = '{1'b1, 8'h14, 32'hDEAD_BEEF, 8'h14, 32'h0};
        vecs[7] = '{1'b1, 8'h00, 32'hFFFF_FFFC, 8'h00, 32'h0};
        vecs[8] = '{1'b1, 8'hFC, 32'h1234_5678, 8'hFC, 32'h5247_0003};
        raddrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h24,
                   8'h2C, 8'h3C, 8'h84, 8'hFC, 8'h40, 8'h7C, 8'h18, 8'h3D};

        idle_inputs();
        m_reset();
        repeat (2) @(negedge clk);
        chk("reset rvalid", 64'(bus.reg_bus_rvalid), 64'd0);
        chk("reset rdata", 64'(bus.reg_bus_rdata), 64'd0);
        chk("reset count_en", 64'(count_en), 64'd0);
        chk("reset alert", 64'(alert), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata);
            rd_chk(vecs[i].raddr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // three reads on consecutive cycles answered in order
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 16'h0008);
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 16'h00FC);
        chk("b2b0", {32'(bus.reg_bus_rvalid), bus.reg_bus_rdata}, {32'd1, 32'hA5A5_1234});
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 16'h000C);
        chk("b2b1", {32'(bus.reg_bus_rvalid), bus.reg_bus_rdata}, {32'd1, 32'h5247_0003});
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 16'h0);
        chk("b2b2", {32'(bus.reg_bus_rvalid), bus.reg_bus_rdata}, {32'd1, 32'h0000_00FF});
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 16'h0);
        chk("b2b end", {32'(bus.reg_bus_rvalid), bus.reg_bus_rdata}, {32'd0, 32'h0000_00FF});

        // masked event counting
        wr(8'h0C, 32'h05);
        wr(8'h00, 32'h1);
        ev_g = 8'hFF;
        repeat (10) cycle(1'b0, 16'h0, 32'h0, 1'b0, 16'h0);
        ev_g = 8'h00;
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h0);
        rd_chk(8'h20, 32'd10, "cnt0");
        rd_chk(8'h24, 32'd0, "cnt1");
        rd_chk(8'h28, 32'd10, "cnt2");
        rd_chk(8'h04, 32'd1, "snapcnt");
        rd_chk(8'h10, 32'd11, "cycles");

        // clear-on-snap keeps the event of the snapshot cycle
        wr(8'h0C, 32'hFF);
        wr(8'h00, 32'h3);
        ev_g = 8'h01;
        wr(8'h04, 32'h0);
        repeat (19) cycle(1'b0, 16'h0, 32'h0, 1'b0, 16'h0);
        wr(8'h04, 32'h0);
        rd_chk(8'h20, 32'd20, "cos cnt0");
        ev_g = 8'h00;
        wr(8'h00, 32'h0);

        // overflow from a preloaded counter
        dut.cnt_q[0] = 32'hFFFF_FFFF;
        m_cnt[0] = 32'hFFFF_FFFF;
        wr(8'h00, 32'h1);
        ev_g = 8'h01;
        cycle(1'b0, 16'h0, 32'h0, 1'b0, 16'h0);
        ev_g = 8'h00;
        chk("ovf alert", 64'(alert), 64'd1);
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h0);
        rd_chk(8'h20, SAT ? 32'hFFFF_FFFF : 32'h0, "ovf cnt0");
        rd_chk(8'h84, 32'd1, "alert reg");
        wr(8'h84, 32'h0);
        chk("alert clr", 64'(alert), 64'd0);
        rd_chk(8'h84, 32'd0, "alert reg clr");

        // reset with a read in flight
        wr(8'h08, 32'h1357_9BDF);
        wr(8'h00, 32'h1);
        rd_chk(8'h08, 32'h1357_9BDF, "pre-rst");
        cycle(1'b0, 16'h0, 32'h0, 1'b1, 16'h0008);
        #2;
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst rvalid", 64'(bus.reg_bus_rvalid), 64'd0);
        chk("rst rdata", 64'(bus.reg_bus_rdata), 64'd0);
        chk("rst count_en", 64'(count_en), 64'd0);
        chk("rst alert", 64'(alert), 64'd0);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) cycle(1'b0, 16'h0, 32'h0, 1'b0, 16'h0);
        rd_chk(8'h08, 32'h0, "post-rst scratch");
        rd_chk(8'h0C, 32'hFF, "post-rst mask");

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [7:0]  wa;
            logic [31:0] wd;
            wa = raddrs[$urandom_range(0, 15)];
            if ($urandom_range(0, 3) == 0) wa = 8'h00;
            wd = $urandom;
            ev_g = 8'($urandom);
            cycle(1'($urandom_range(0, 2) == 0), {8'h0, wa}, wd,
                  1'($urandom_range(0, 1)), {8'($urandom), raddrs[$urandom_range(0, 15)]});
        end
        ev_g = 8'h00;
        repeat (3) cycle(1'b0, 16'h0, 32'h0, 1'b0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
